// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Successor of a requester index, wrapping at n (works for any n, not just powers of two).
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_priority_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   int unsigned        off;
   int unsigned        sum;

   always_comb begin
      // Rotate so rr_ptr lands on bit 0, find the lowest set bit, then undo the rotation.
      dbl   = {req, req};
      rot   = N_REQ'(dbl >> rr_ptr);
      found = |rot;
      off   = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = unsigned'(i);
      end
      sum = off + 32'(rr_ptr);
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = ID_W'(sum);
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for one shared resource, with grant hold and a per-grant quantum limit.
module rr_grant_scheduler
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     timeout,
   output logic [$clog2(N_REQ)-1:0] timeout_id
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic             timeout_q, timeout_d;
   logic [ID_W-1:0]  timeout_id_q, timeout_id_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      hold_cnt_d    = hold_cnt_q;
      rr_ptr_d      = rr_ptr_q;
      timeout_d     = 1'b0;
      timeout_id_d  = '0;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d       = ARB_GRANT;
               grant_d       = N_REQ'(1) << pick_idx;
               grant_valid_d = 1'b1;
               grant_id_d    = pick_idx;
               hold_cnt_d    = CNT_W'(1);
            end
         end
         ARB_GRANT: begin
            // A drop of req wins over quantum expiry, so that case is a plain release.
            if (!req[grant_id_q] || hold_cnt_q == CNT_W'(MAX_HOLD)) begin
               state_d       = ARB_IDLE;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               grant_id_d    = '0;
               hold_cnt_d    = '0;
               rr_ptr_d      = ID_W'(rr_next(32'(grant_id_q), N_REQ));
               if (req[grant_id_q]) begin
                  timeout_d    = 1'b1;
                  timeout_id_d = grant_id_q;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         timeout_q     <= 1'b0;
         timeout_id_q  <= '0;
         hold_cnt_q    <= '0;
         rr_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         timeout_q     <= timeout_d;
         timeout_id_q  <= timeout_id_d;
         hold_cnt_q    <= hold_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign timeout     = timeout_q;
   assign timeout_id  = timeout_id_q;

endmodule
